// File: rtl/voice_mixer_pdm.sv
// Multi-voice volume mixer: serial multiply-accumulate over a snapshot of all
// voices, saturation to an offset-binary sample, and a first-order PDM of the result.
module voice_mixer_pdm #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_BITS  = 12,
  parameter int VOL_BITS   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_strobe,
  input  logic [NUM_VOICES*DATA_BITS-1:0]  voice_data,
  input  logic [NUM_VOICES*VOL_BITS-1:0]   volume,
  output logic [DATA_BITS-1:0]             mix_out,
  output logic                             mix_valid,
  output logic                             busy,
  output logic                             overrun,
  output logic                             pdm_out,
  output logic [1:0]                       state_dbg
);

  localparam int ACC_W = DATA_BITS + VOL_BITS + 4;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'((1 << (DATA_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SUM_MIN = -SUM_MAX - ACC_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SAT = 2'd2} state_t;

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx;
  logic signed [ACC_W-1:0]         acc;
  logic [NUM_VOICES*DATA_BITS-1:0] snap_data;
  logic [NUM_VOICES*VOL_BITS-1:0]  snap_vol;
  logic [DATA_BITS-1:0]            pdm_acc;

  logic [DATA_BITS-1:0]                cur_sample;
  logic [VOL_BITS-1:0]                 cur_vol;
  logic signed [DATA_BITS-1:0]         s_sample;
  logic signed [DATA_BITS+VOL_BITS:0]  product;
  logic signed [DATA_BITS+VOL_BITS:0]  term;
  logic signed [ACC_W-1:0]             term_ext;
  logic signed [ACC_W-1:0]             clamped;
  logic [DATA_BITS:0]                  pdm_sum;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Offset-binary to two's complement is just an MSB flip.
  assign cur_sample = snap_data[int'(idx)*DATA_BITS +: DATA_BITS];
  assign cur_vol    = snap_vol[int'(idx)*VOL_BITS +: VOL_BITS];
  assign s_sample   = {~cur_sample[DATA_BITS-1], cur_sample[DATA_BITS-2:0]};
  assign product    = s_sample * $signed({1'b0, cur_vol});
  assign term       = product >>> VOL_BITS;
  assign term_ext   = ACC_W'(term);

  always_comb begin
    clamped = acc;
    if (acc > SUM_MAX)      clamped = SUM_MAX;
    else if (acc < SUM_MIN) clamped = SUM_MIN;
  end

  assign pdm_sum = {1'b0, pdm_acc} + {1'b0, mix_out};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_strobe) state_nxt = ACCUM;
      ACCUM:   if (idx == IDX_W'(NUM_VOICES - 1)) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      snap_data <= '0;
      snap_vol  <= '0;
      mix_out   <= DATA_BITS'(1 << (DATA_BITS - 1));
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= (state == SAT);
      if (sample_strobe && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            snap_data <= voice_data;
            snap_vol  <= volume;
            acc       <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + term_ext;
          idx <= idx + IDX_W'(1);
        end
        SAT: mix_out <= {~clamped[DATA_BITS-1], clamped[DATA_BITS-2:0]};
        default: ;
      endcase
    end
  end

  // The carry out of the low DATA_BITS is the PDM bit; only the low bits persist.
  always_ff @(posedge clk) begin
    if (rst) begin
      pdm_acc <= '0;
      pdm_out <= 1'b0;
    end else begin
      pdm_acc <= pdm_sum[DATA_BITS-1:0];
      pdm_out <= pdm_sum[DATA_BITS];
    end
  end

endmodule
